ysyx_23060229_lsu: RTL and testbench
====================================

YSYX_23060229_LSU -- requirements
Module: ysyx_23060229_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, the maximum number of cycles to wait for a memory response.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1, the request handshake from the execute stage.
REQ-005 SHALL have ports is_store input 1, op input 3 (funct3), addr input 32, wdata input 32, rd input 5.
REQ-006 SHALL have ports mem_req_valid output 1 and mem_req_ready input 1, the memory request handshake.
REQ-007 SHALL have ports mem_addr output 32 (word-aligned), mem_wen output 1, mem_wstrb output 4, mem_wdata output 32.
REQ-008 SHALL have ports mem_rsp_valid input 1 and mem_rdata input 32.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1, out_rdata output 32, out_rd output 5, out_wen output 1, out_err output 1, the result to write-back.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-011 SHALL drive in_ready=1 only in IDLE with rst low.
REQ-012 SHALL latch is_store, op, addr, wdata and rd on in_valid&&in_ready.
REQ-013 SHALL treat these op values as legal: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-014 SHALL treat any other op value as illegal: on accept, go IDLE->RESP with out_err=1, out_wen=0, out_rdata=0, and no memory request.
REQ-015 SHALL treat halfword ops with addr[0]!=0, and word ops with addr[1:0]!=0, as misaligned, handled as in REQ-014.
REQ-016 SHALL go IDLE->REQ on a legal, aligned accept.
REQ-017 SHALL hold mem_req_valid=1 in REQ with mem_addr={addr[31:2],2'b00} and all request fields stable until mem_req_ready=1, then go to WAIT.
REQ-018 SHALL drive store strobes as SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111.
REQ-019 SHALL drive mem_wdata as wdata shifted left by 8*addr[1:0], and mem_wen=is_store.
REQ-020 SHALL drive mem_wen=0 and mem_wstrb=0 for loads.
REQ-021 SHALL sample mem_rsp_valid only in WAIT; when it is 1, capture the result and go to RESP.
REQ-022 SHALL produce the load result from the byte lane mem_rdata>>(8*addr[1:0]): LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged.
REQ-023 SHALL complete a store on mem_rsp_valid as a write ack, with out_rdata=0 and out_wen=0.
REQ-024 SHALL clear a wait counter on entry to WAIT and increment it each WAIT cycle without a response.
REQ-025 SHALL, when the counter reaches TIMEOUT_CYC-1 with no response, go to RESP with out_err=1, out_wen=0, out_rdata=0.
REQ-026 SHALL give priority to a response over timeout when both fall in the same cycle.
REQ-027 SHALL hold out_valid=1 in RESP with out_rdata, out_rd, out_wen and out_err stable until out_ready=1, then go to IDLE.
REQ-028 SHALL drive out_wen=1 for a successful load with rd!=0, and out_wen=0 when rd=0.
REQ-029 SHALL ignore mem_rsp_valid in IDLE, REQ and RESP, so stray or late responses have no effect.
REQ-030 SHALL have a minimum latency of accept at edge T, mem_req_valid at T+1, WAIT entered at T+2, and out_valid at T+3 when mem_req_ready=1 and mem_rsp_valid=1 on first opportunity.
REQ-031 SHALL have at most one transaction outstanding; in_ready=0 from REQ until the RESP->IDLE edge.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, set state=IDLE, clear the counter, and drive all outputs to 0, including in_ready.
REQ-033 SHALL, on reset in REQ, WAIT or RESP, abandon the transaction with no out_valid, and ignore its later mem_rsp_valid.
REQ-034 SHALL set in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-035 SHALL cover LB with addr=0x8000_0003, mem_rdata=0x80FF_1234 -> out_rdata=0xFFFF_FF80, out_wen=1, out_valid at T+3.
REQ-036 SHALL cover SH with addr=0x8000_0002, wdata=0x0000_ABCD -> mem_wstrb=4'b1100, mem_wdata=0xABCD_0000, mem_addr=0x8000_0000, out_wen=0.
REQ-037 SHALL cover LW with addr=0x8000_0001 -> no mem_req_valid, out_err=1, out_valid the cycle after accept.
REQ-038 SHALL cover a load with no mem_rsp_valid -> out_err=1 after exactly TIMEOUT_CYC WAIT cycles, then a normal LBU succeeds.
REQ-039 SHALL cover mem_req_ready held low 5 cycles and out_ready held low 3 cycles -> request and result fields stable throughout, exactly one completion.
REQ-040 SHALL cover rst asserted in WAIT, then mem_rsp_valid=1 -> no out_valid, in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/ysyx_23060229_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_23060229_lsu
//
// Load/store unit between the execute stage and a word-addressed memory
// port. One transaction at a time: accept a request, issue one aligned
// memory access (or fail it immediately if illegal/misaligned), wait for the
// memory response (bounded by TIMEOUT_CYC), then present the result to
// write-back.
//
// Handshake rule used on every valid/ready pair in this block: a transfer
// happens on a rising clk edge where valid && ready are both 1. Once a
// producer raises valid it keeps valid and its payload stable until that
// edge. The response channel (mem_rsp_valid) has no ready; it is only
// looked at while the FSM is in WAIT.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request from execute stage
//   is_store, op, addr,   request payload (op is the RISC-V funct3)
//   wdata, rd
//   mem_req_valid/_ready  memory request handshake
//   mem_addr, mem_wen,    memory request payload (mem_addr is word-aligned,
//   mem_wstrb, mem_wdata  write data/strobes already placed in byte lanes)
//   mem_rsp_valid,        memory response (read data or write ack)
//   mem_rdata
//   out_valid / out_ready result handshake to write-back
//   out_rdata, out_rd,    result payload
//   out_wen, out_err
//   dbg_state             current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)
// ---------------------------------------------------------------------------
module ysyx_23060229_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  // request from execute
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_store,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  // memory request
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  // memory response
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  // result to write-back
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_err,
  // debug
  output logic [1:0]  dbg_state
);

  // Counter only needs to reach TIMEOUT_CYC-1.
  localparam int unsigned  CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic          is_store_q;
  logic [2:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [4:0]    rd_q;

  // Result held for write-back
  logic [31:0]   res_rdata_q;
  logic          res_wen_q;
  logic          res_err_q;

  logic [CW-1:0] wait_cnt_q;

  // -------------------------------------------------------------------------
  // Request classification (on the live inputs, used at accept time)
  // -------------------------------------------------------------------------
  logic accept;
  logic op_legal;
  logic addr_aligned;
  logic req_ok;
  logic timeout_hit;

  assign accept = in_valid && in_ready;

  always_comb begin
    op_legal = 1'b0;
    if (is_store) begin
      case (op)
        3'b000, 3'b001, 3'b010: op_legal = 1'b1;
        default:                op_legal = 1'b0;
      endcase
    end else begin
      case (op)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_legal = 1'b1;
        default:                                op_legal = 1'b0;
      endcase
    end
  end

  // op[1:0] encodes the access size for every legal op: 00 byte, 01 half, 10 word.
  always_comb begin
    addr_aligned = 1'b1;
    case (op[1:0])
      2'b01:   addr_aligned = (addr[0] == 1'b0);
      2'b10:   addr_aligned = (addr[1:0] == 2'b00);
      default: addr_aligned = 1'b1;
    endcase
  end

  assign req_ok      = op_legal && addr_aligned;
  assign timeout_hit = (wait_cnt_q == CNT_LAST);

  // -------------------------------------------------------------------------
  // Load data extraction from the addressed byte lane
  // -------------------------------------------------------------------------
  logic [31:0] lane;
  logic [31:0] load_data;

  assign lane = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = 32'h0;
    case (op_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_data = lane;
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = 32'h0;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = req_ok ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the last counted cycle still wins over the timeout.
        if (mem_rsp_valid || timeout_hit) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (payloads are zero outside the state that owns them)
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = 32'h0;
    mem_wen       = 1'b0;
    mem_wstrb     = 4'h0;
    mem_wdata     = 32'h0;
    out_valid     = 1'b0;
    out_rdata     = 32'h0;
    out_rd        = 5'h0;
    out_wen       = 1'b0;
    out_err       = 1'b0;
    dbg_state     = state;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          in_ready = 1'b1;
        end
        S_REQ: begin
          mem_req_valid = 1'b1;
          mem_addr      = {addr_q[31:2], 2'b00};
          mem_wen       = is_store_q;
          mem_wdata     = wdata_q << {addr_q[1:0], 3'b000};
          if (is_store_q) begin
            case (op_q[1:0])
              2'b00:   mem_wstrb = 4'b0001 << addr_q[1:0];
              2'b01:   mem_wstrb = 4'b0011 << addr_q[1:0];
              default: mem_wstrb = 4'b1111;
            endcase
          end
        end
        S_RESP: begin
          out_valid = 1'b1;
          out_rdata = res_rdata_q;
          out_rd    = rd_q;
          out_wen   = res_wen_q;
          out_err   = res_err_q;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: request latch, wait counter, result capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q  <= 1'b0;
      op_q        <= 3'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rd_q        <= 5'h0;
      res_rdata_q <= 32'h0;
      res_wen_q   <= 1'b0;
      res_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      if (accept) begin
        is_store_q <= is_store;
        op_q       <= op;
        addr_q     <= addr;
        wdata_q    <= wdata;
        rd_q       <= rd;
        if (!req_ok) begin
          res_rdata_q <= 32'h0;
          res_wen_q   <= 1'b0;
          res_err_q   <= 1'b1;
        end
      end

      if (state == S_REQ && mem_req_ready) begin
        wait_cnt_q <= '0;
      end

      if (state == S_WAIT) begin
        if (mem_rsp_valid) begin
          res_err_q <= 1'b0;
          if (is_store_q) begin
            res_rdata_q <= 32'h0;
            res_wen_q   <= 1'b0;
          end else begin
            res_rdata_q <= load_data;
            res_wen_q   <= (rd_q != 5'd0);
          end
        end else if (timeout_hit) begin
          res_rdata_q <= 32'h0;
          res_wen_q   <= 1'b0;
          res_err_q   <= 1'b1;
        end else begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060229_lsu.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060229_lsu: a table of request vectors with expected
// memory-request fields and write-back results, a bench-side memory model
// driven by tasks, a scoreboard queue of expected results, plus hand-written
// sequences for timeout, back-pressure and reset-in-flight.
// ---------------------------------------------------------------------------
module tb_ysyx_23060229_lsu;

  localparam int TMO = 12;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_store = 1'b0;
  logic [2:0]  op = 3'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [4:0]  rd = 5'h0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_err;
  logic [1:0]  dbg_state;

  ysyx_23060229_lsu #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_store(is_store), .op(op), .addr(addr), .wdata(wdata), .rd(rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_rd(out_rd), .out_wen(out_wen), .out_err(out_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  // expected result = {err, wen, rdata, rd}
  logic [38:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rsp;
    logic        exp_req;
    logic [3:0]  exp_strb;
    logic [31:0] exp_mwd;
    logic        exp_err;
    logic        exp_wen;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] wd, input logic [4:0] r, input logic [31:0] rsp,
                              input logic req, input logic [3:0] strb, input logic [31:0] mwd,
                              input logic err, input logic wen, input logic [31:0] rdat);
    vec_t v;
    v.st = st; v.op = o; v.addr = a; v.wdata = wd; v.rd = r; v.rsp = rsp;
    v.exp_req = req; v.exp_strb = strb; v.exp_mwd = mwd;
    v.exp_err = err; v.exp_wen = wen; v.exp_rdata = rdat;
    return v;
  endfunction

  // ---------------- driver: one full transaction ----------------
  // rsp_dly < 0 means memory never answers (timeout expected).
  task automatic run_txn(input vec_t v, input int req_dly, input int rsp_dly, input int out_dly);
    int n;
    logic [38:0] f;
    exp_q.push_back({v.exp_err, v.exp_wen, v.exp_rdata, v.rd});
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; is_store = v.st; op = v.op; addr = v.addr; wdata = v.wdata; rd = v.rd;
    step();
    // scramble request inputs to prove they were latched
    in_valid = 1'b0; is_store = ~v.st; op = 3'($urandom); addr = $urandom; wdata = $urandom;
    rd = 5'($urandom);
    if (v.exp_req) begin
      chk("req_valid_t1", mem_req_valid, 1);
      chk("in_ready_busy", in_ready, 0);
      chk("out_valid_early", out_valid, 0);
      for (int i = 0; i <= req_dly; i++) begin
        if (i > 0) step();
        chk("req_hold_valid", mem_req_valid, 1);
        chk("req_fields", {mem_addr, mem_wen, mem_wstrb},
            {v.addr[31:2], 2'b00, v.st, v.exp_strb});
        if (v.st) chk("req_wdata", mem_wdata, v.exp_mwd);
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("req_drop", mem_req_valid, 0);
      chk("in_wait", dbg_state, 2);
      if (rsp_dly < 0) begin
        n = 0;
        while (!out_valid && n < TMO + 10) begin
          step();
          n++;
        end
        chk("timeout_wait_cycles", n, TMO);
      end else begin
        for (int i = 0; i < rsp_dly; i++) begin
          step();
          chk("no_out_in_wait", out_valid, 0);
        end
        mem_rsp_valid = 1'b1; mem_rdata = v.rsp;
        step();
        mem_rsp_valid = 1'b0; mem_rdata = $urandom;
      end
    end else begin
      chk("no_mem_req", mem_req_valid, 0);
    end
    chk("out_valid", out_valid, 1);
    for (int i = 0; i < out_dly; i++) begin
      f = (exp_q.size() > 0) ? exp_q[0] : 39'h0;
      chk("out_hold", {out_err, out_wen, out_rdata, out_rd}, f);
      step();
      chk("out_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      f = exp_q.pop_front();
      chk("result", {out_err, out_wen, out_rdata, out_rd}, f);
    end
    step();
    out_ready = 1'b0;
    chk("out_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  // ---------------- vector table ----------------
  vec_t vecs[16];

  initial begin
    //            st  op      addr          wdata         rd     rsp            req strb     mwdata        err wen rdata
    vecs[0]  = mk(0, 3'b000, 32'h8000_0003, 32'h0,        5'd5,  32'h80FF_1234, 1, 4'b0000, 32'h0,        0, 1, 32'hFFFF_FF80);
    vecs[1]  = mk(1, 3'b001, 32'h8000_0002, 32'h0000_ABCD,5'd3,  32'h0,         1, 4'b1100, 32'hABCD_0000,0, 0, 32'h0);
    vecs[2]  = mk(0, 3'b010, 32'h8000_0001, 32'h0,        5'd9,  32'h0,         0, 4'b0000, 32'h0,        1, 0, 32'h0);
    vecs[3]  = mk(0, 3'b010, 32'h8000_1004, 32'h0,        5'd31, 32'hDEAD_BEEF, 1, 4'b0000, 32'h0,        0, 1, 32'hDEAD_BEEF);
    vecs[4]  = mk(0, 3'b001, 32'h0000_0012, 32'h0,        5'd1,  32'h8001_7FFF, 1, 4'b0000, 32'h0,        0, 1, 32'hFFFF_8001);
    vecs[5]  = mk(0, 3'b101, 32'h0000_0012, 32'h0,        5'd2,  32'h8001_7FFF, 1, 4'b0000, 32'h0,        0, 1, 32'h0000_8001);
    vecs[6]  = mk(0, 3'b100, 32'h0000_0021, 32'h0,        5'd0,  32'h1234_56F0, 1, 4'b0000, 32'h0,        0, 0, 32'h0000_0056);
    vecs[7]  = mk(1, 3'b000, 32'h0000_0041, 32'h0000_00A5,5'd4,  32'h0,         1, 4'b0010, 32'h0000_A500,0, 0, 32'h0);
    vecs[8]  = mk(1, 3'b010, 32'h0000_0080, 32'hCAFE_F00D,5'd6,  32'h0,         1, 4'b1111, 32'hCAFE_F00D,0, 0, 32'h0);
    vecs[9]  = mk(0, 3'b011, 32'h0000_0000, 32'h0,        5'd7,  32'h0,         0, 4'b0000, 32'h0,        1, 0, 32'h0);
    vecs[10] = mk(1, 3'b100, 32'h0000_0000, 32'h1,        5'd8,  32'h0,         0, 4'b0000, 32'h0,        1, 0, 32'h0);
    vecs[11] = mk(1, 3'b001, 32'h0000_0003, 32'h1,        5'd10, 32'h0,         0, 4'b0000, 32'h0,        1, 0, 32'h0);
    vecs[12] = mk(0, 3'b000, 32'h0000_0000, 32'h0,        5'd11, 32'hFFFF_FF7F, 1, 4'b0000, 32'h0,        0, 1, 32'h0000_007F);
    vecs[13] = mk(1, 3'b010, 32'h0000_0002, 32'h1,        5'd12, 32'h0,         0, 4'b0000, 32'h0,        1, 0, 32'h0);
    vecs[14] = mk(0, 3'b001, 32'h0000_0001, 32'h0,        5'd13, 32'h0,         0, 4'b0000, 32'h0,        1, 0, 32'h0);
    vecs[15] = mk(0, 3'b101, 32'h0000_0000, 32'h0,        5'd14, 32'hFFFF_8000, 1, 4'b0000, 32'h0,        0, 1, 32'h0000_8000);
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    logic [31:0] r;
    #1;
    step();
    step();
    // outputs held low during reset
    chk("rst_in_ready", in_ready, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_first_cycle", in_ready, 1);

    // stray responses in IDLE must be ignored
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    step();
    mem_rsp_valid = 1'b0;
    chk("stray_rsp_out_valid", out_valid, 0);
    chk("stray_rsp_state", dbg_state, 0);

    // table vectors at minimum latency
    for (int i = 0; i < 16; i++) begin
      run_txn(vecs[i], 0, 0, 0);
      step();
    end

    // timeout, then a normal LBU succeeds
    v = mk(0, 3'b000, 32'h8000_0010, 32'h0, 5'd7, 32'h0, 1, 4'b0000, 32'h0, 1, 0, 32'h0);
    run_txn(v, 0, -1, 0);
    v = mk(0, 3'b100, 32'h8000_0013, 32'h0, 5'd7, 32'hAB00_0000, 1, 4'b0000, 32'h0, 0, 1, 32'h0000_00AB);
    run_txn(v, 0, 0, 0);

    // response lands on the last counted WAIT cycle: response wins
    v = mk(0, 3'b010, 32'h0000_0100, 32'h0, 5'd15, 32'h5A5A_A5A5, 1, 4'b0000, 32'h0, 0, 1, 32'h5A5A_A5A5);
    run_txn(v, 0, TMO - 1, 0);

    // back-pressure: request stalled 5 cycles, result stalled 3 cycles
    run_txn(vecs[1], 5, 2, 3);
    chk("single_completion", exp_q.size(), 0);
    step();
    step();
    chk("no_second_completion", out_valid, 0);

    // random aligned word loads with random delays
    for (int i = 0; i < 8; i++) begin
      r = $urandom; r[1:0] = 2'b00;
      v = mk(0, 3'b010, r, 32'h0, 5'($urandom_range(0, 31)), $urandom, 1, 4'b0000, 32'h0, 0, 0, 32'h0);
      v.exp_rdata = v.rsp;
      v.exp_wen = (v.rd != 5'd0);
      run_txn(v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // reset while in WAIT, then a late response
    in_valid = 1'b1; is_store = 1'b0; op = 3'b010; addr = 32'h0000_0200; rd = 5'd3;
    step();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("rst_seq_in_wait", dbg_state, 2);
    rst = 1'b1;
    step();
    chk("rst_mid_in_ready", in_ready, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_state", dbg_state, 0);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    chk("rst_release_in_ready", in_ready, 1);
    step();
    mem_rsp_valid = 1'b0;
    chk("late_rsp_out_valid", out_valid, 0);
    chk("late_rsp_state", dbg_state, 0);
    step();
    chk("late_rsp_out_valid2", out_valid, 0);

    // normal op after the abandoned one
    run_txn(vecs[0], 1, 1, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
